display_scheduler: RTL and testbench

Time-shares the 4-digit seven-segment display among four requesters (e.g. FSM state readout, counter value, error code, debug value). Produces the four BCD nibbles `d3..d0` that feed the display multiplexing driver. Uses level-sensitive request/grant, round-robin arbitration and a minimum on-screen hold time, so a value stays readable before ownership rotates.

---
 rtl/display_scheduler.sv | 136 +++++++++++++
 tb/tb_display_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// ---------------------------------------------------------------------------
// display_scheduler
//   Time-shares a 4-digit seven-segment display among four requesters using
//   level-sensitive request/grant, round-robin arbitration and a minimum
//   on-screen hold time so a value stays readable before ownership rotates.
//
// Parameters
//   HOLD_CYCLES  minimum clk cycles an owner keeps the display while others
//                wait (>= 1).
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req[3:0]    level requests, held while the display is wanted
//   req_data    requester i's digits at [16*i+15:16*i] (d3 top nibble)
//   grant[3:0]  one-hot (or zero) current owner, registered
//   busy        any grant active, registered
//   d3..d0      digits to the display driver, registered; 4'hF = blank
//
// Build option
//   DISP_SCHED_PREEMPT_EN  when defined, requester 0 is urgent and takes the
//                          display from any other owner on the next edge.
// ---------------------------------------------------------------------------
module display_scheduler #(
    parameter int HOLD_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [3:0]  d3,
    output logic [3:0]  d2,
    output logic [3:0]  d1,
    output logic [3:0]  d0
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, nxt_state;
    logic [1:0]    owner, nxt_owner;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [3:0]    others;
    logic          take;

    // First set bit of m searching upward from p+1 with wrap. Scanning from
    // the farthest candidate to the nearest lets the nearest one win.
    function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (m[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        // Requests other than the current owner; used both for rotation and
        // so that a releasing owner is never re-picked on its release edge.
        others    = req & ~(4'b0001 << owner);
        nxt_state = state;
        nxt_owner = owner;
        nxt_cnt   = cnt;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    nxt_state = OWN;
                    nxt_owner = rr_pick(req, ptr);
                    take      = 1'b1;
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    // Release is honoured regardless of the hold counter.
                    if (|others) begin
                        nxt_owner = rr_pick(others, ptr);
                        take      = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end
                end else if (cnt != '0) begin
                    nxt_cnt = cnt - CW'(1);
                end else if (|others) begin
                    nxt_owner = rr_pick(others, ptr);
                    take      = 1'b1;
                end
                // Hold expired with nobody waiting: keep owner, counter stays 0.
            end
            default: nxt_state = IDLE;
        endcase
`ifdef DISP_SCHED_PREEMPT_EN
        // Requester 0 overrides hold and release handling of any other owner.
        if (state == OWN && owner != 2'd0 && req[0]) begin
            nxt_state = OWN;
            nxt_owner = 2'd0;
            take      = 1'b1;
        end
`endif
        if (take) nxt_cnt = RELOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd3;
            cnt   <= '0;
            grant <= 4'b0000;
            busy  <= 1'b0;
            {d3, d2, d1, d0} <= 16'hFFFF;
        end else begin
            state <= nxt_state;
            owner <= nxt_owner;
            cnt   <= nxt_cnt;
            if (take) ptr <= nxt_owner;
            if (nxt_state == OWN) begin
                grant <= 4'b0001 << nxt_owner;
                busy  <= 1'b1;
                // Digits follow the owner chosen on this same edge.
                {d3, d2, d1, d0} <= req_data[{nxt_owner, 4'b0000} +: 16];
            end else begin
                grant <= 4'b0000;
                busy  <= 1'b0;
                {d3, d2, d1, d0} <= 16'hFFFF;
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [63:0] req_data = '0;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  d3, d2, d1, d0;

    display_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .grant(grant), .busy(busy), .d3(d3), .d2(d2), .d1(d1), .d0(d0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the display, how many more contended cycles
    // the owner may keep it, and where round-robin search resumes.
    int          m_own;   // -1 = nobody
    int          m_left;
    int          m_ptr;
    logic [15:0] m_d;

    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 1; k <= 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1; m_left = 0; m_ptr = 3; m_d = 16'hFFFF;
        end else begin
            int nxt;
            logic [3:0] oth;
            nxt = m_own;
            if (m_own < 0) begin
                nxt = (|req) ? pick(req, m_ptr) : -1;
            end else begin
                oth = req;
                oth[m_own] = 1'b0;
`ifdef DISP_SCHED_PREEMPT_EN
                if (req[0] && m_own != 0) nxt = 0;
                else
`endif
                if (!req[m_own])               nxt = (|oth) ? pick(oth, m_ptr) : -1;
                else if (m_left > 0)           m_left = m_left - 1;
                else if (|oth)                 nxt = pick(oth, m_ptr);
            end
            // Any change to a new owner, or a fresh grant from idle, restarts the hold.
            if (nxt >= 0 && (nxt != m_own || m_own < 0 ||
                             (req[0] && nxt == 0 && m_own != 0))) begin
                m_left = HOLD - 1;
                m_ptr  = nxt;
            end
            m_own = nxt;
            m_d   = (nxt < 0) ? 16'hFFFF : req_data[16*nxt +: 16];
        end
    end

    always @(negedge clk) begin
        chk("grant", {28'd0, grant}, (m_own < 0) ? 32'd0 : (32'd1 << m_own));
        chk("busy",  {31'd0, busy},  {31'd0, m_own >= 0});
        chk("digits", {16'd0, d3, d2, d1, d0}, {16'd0, m_d});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset and idle
        cyc(2);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_digits", {16'd0, d3, d2, d1, d0}, 32'h0000FFFF);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_digits", {16'd0, d3, d2, d1, d0}, 32'h0000FFFF);

        // Single request with live data tracking
        req = 4'b0010; req_data[31:16] = 16'h1234;
        cyc(1);
        chk("single_grant", {28'd0, grant}, 32'h2);
        chk("single_digits", {16'd0, d3, d2, d1, d0}, 32'h1234);
        req_data[31:16] = 16'h5678;
        cyc(1);
        chk("track_digits", {16'd0, d3, d2, d1, d0}, 32'h5678);
        req = 4'b0000;
        cyc(1);
        chk("release_idle", {27'd0, busy, grant}, 32'h0);

        // Rotation under full contention from reset
        rst_n = 1'b0; req = 4'b1111; req_data = 64'hDDDD_CCCC_BBBB_AAAA;
        cyc(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk("rotate", {28'd0, grant}, 32'd1 << (((k - 1) / 4) % 4));
        end

        // Early release of owner 2 with 3 pending, then release to idle
        rst_n = 1'b0; req = 4'b0000;
        cyc(1);
        rst_n = 1'b1; req = 4'b0100;
        cyc(1);
        chk("own2", {28'd0, grant}, 32'h4);
        req = 4'b1100;
        cyc(1);
        req = 4'b1000;
        cyc(1);
        chk("early_release", {28'd0, grant}, 32'h8);
        req = 4'b0000;
        cyc(1);
        chk("to_idle", {16'd0, d3, d2, d1, d0}, 32'h0000FFFF);

        // Owner 3 releases while 0 requests: pointer wraps to 0
        req = 4'b1000;
        cyc(1);
        req = 4'b0001;
        cyc(1);
        chk("wrap", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        cyc(1);

        // Requester 0 arrives while 1 owns
        req = 4'b0010;
        cyc(1);
        req = 4'b0011;
`ifdef DISP_SCHED_PREEMPT_EN
        for (int k = 0; k < 4; k++) begin cyc(1); chk("preempt", {28'd0, grant}, 32'h1); end
        cyc(1); chk("after_preempt", {28'd0, grant}, 32'h2);
`else
        for (int k = 0; k < 3; k++) begin cyc(1); chk("no_preempt", {28'd0, grant}, 32'h2); end
        cyc(1); chk("after_hold", {28'd0, grant}, 32'h1);
`endif
        req = 4'b0000;
        cyc(2);

        // Random traffic against the model, with occasional mid-grant reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            if ($urandom_range(1) == 0) req_data = {$urandom, $urandom};
            if ($urandom_range(99) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst", {11'd0, busy, grant, d3, d2, d1, d0}, 32'h0000FFFF);
                cyc(1);
                rst_n = 1'b1;
            end
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
